// File: rtl/sram_bridge.sv
`default_nettype none
// ============================================================================
// Module   : sram_bridge
// Purpose  : AVR external-bus to asynchronous SRAM bridge. Synchronises the
//            AVR strobes and ALE, latches the address and write data, and
//            sequences SRAM CE/WE/OE with a configurable wait-state count.
//            Optional address auto-increment after each completed access.
//            All tri-state control is explicit (data + output-enable pairs).
// Ports    : clk, reset (sync, active low)
//            avr_we_n/avr_oe_n/avr_ale (async), avr_addr, avr_din,
//            avr_dout + avr_dout_oe
//            sram_addr, sram_din, sram_dout + sram_dout_oe,
//            sram_ce_n/sram_we_n/sram_oe_n
//            busy (not IDLE), err (sticky protocol error)
// Revision : 1.0 - initial parametrised release
// ============================================================================
module sram_bridge #(
  parameter int DWIDTH      = 8,
  parameter int AWIDTH      = 17,
  parameter int WAIT_CYCLES = 2,
  parameter int AUTO_INC    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              avr_we_n,
  input  logic              avr_oe_n,
  input  logic              avr_ale,
  input  logic [AWIDTH-1:0] avr_addr,
  input  logic [DWIDTH-1:0] avr_din,
  output logic [DWIDTH-1:0] avr_dout,
  output logic              avr_dout_oe,
  output logic [AWIDTH-1:0] sram_addr,
  input  logic [DWIDTH-1:0] sram_din,
  output logic [DWIDTH-1:0] sram_dout,
  output logic              sram_dout_oe,
  output logic              sram_ce_n,
  output logic              sram_we_n,
  output logic              sram_oe_n,
  output logic              busy,
  output logic              err
);

  localparam logic [3:0]        c_WAIT     = 4'(WAIT_CYCLES);
  localparam logic [AWIDTH-1:0] c_ADDR_ONE = {{(AWIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WR_SETUP = 3'd1,
    S_WR_PULSE = 3'd2,
    S_WR_HOLD  = 3'd3,
    S_RD_SETUP = 3'd4,
    S_RD_WAIT  = 3'd5,
    S_RD_DRIVE = 3'd6
  } state_t;

  // --------------------------------------------------------------------------
  // Synchronisers, previous-value flops and arm bits
  // --------------------------------------------------------------------------
  logic       r_we_meta, r_we_sync, r_we_prev, r_we_arm;
  logic       r_oe_meta, r_oe_sync, r_oe_prev, r_oe_arm;
  logic       r_ale_meta, r_ale_sync, r_ale_prev, r_ale_arm;
  // r_prime[1] is set once the *_sync flops hold real pin samples rather than
  // their reset values; without it a strobe held low across reset would look
  // inactive for a cycle and arm itself.
  logic [1:0] r_prime;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_we_meta  <= 1'b1;
      r_we_sync  <= 1'b1;
      r_we_prev  <= 1'b1;
      r_we_arm   <= 1'b0;
      r_oe_meta  <= 1'b1;
      r_oe_sync  <= 1'b1;
      r_oe_prev  <= 1'b1;
      r_oe_arm   <= 1'b0;
      r_ale_meta <= 1'b0;
      r_ale_sync <= 1'b0;
      r_ale_prev <= 1'b0;
      r_ale_arm  <= 1'b0;
      r_prime    <= 2'b00;
    end else begin
      r_we_meta  <= avr_we_n;
      r_we_sync  <= r_we_meta;
      r_we_prev  <= r_we_sync;
      r_oe_meta  <= avr_oe_n;
      r_oe_sync  <= r_oe_meta;
      r_oe_prev  <= r_oe_sync;
      r_ale_meta <= avr_ale;
      r_ale_sync <= r_ale_meta;
      r_ale_prev <= r_ale_sync;
      r_prime    <= {r_prime[0], 1'b1};
      if (r_prime[1] && r_we_sync) begin
        r_we_arm <= 1'b1;
      end
      if (r_prime[1] && r_oe_sync) begin
        r_oe_arm <= 1'b1;
      end
      if (r_prime[1] && !r_ale_sync) begin
        r_ale_arm <= 1'b1;
      end
    end
  end

  logic w_we_fall, w_oe_fall, w_ale_rise;
  assign w_we_fall  = r_we_arm  &  r_we_prev  & ~r_we_sync;
  assign w_oe_fall  = r_oe_arm  &  r_oe_prev  & ~r_oe_sync;
  assign w_ale_rise = r_ale_arm & ~r_ale_prev &  r_ale_sync;

  logic w_inc_en;
  generate
    if (AUTO_INC != 0) begin : g_auto_inc
      assign w_inc_en = 1'b1;
    end else begin : g_no_inc
      assign w_inc_en = 1'b0;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // FSM state, wait counter and datapath registers
  // --------------------------------------------------------------------------
  state_t            r_state, w_state_nxt;
  logic [3:0]        r_wcnt, w_wcnt_nxt;
  logic [DWIDTH-1:0] r_wbuf, r_rbuf;
  logic [AWIDTH-1:0] r_addr;
  logic              r_err;

  logic w_wbuf_ld, w_rbuf_ld, w_addr_ld, w_addr_inc, w_err_set;
  logic w_ce_n, w_we_n, w_oe_n, w_sdoe, w_adoe;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_wcnt  <= 4'd0;
      r_wbuf  <= '0;
      r_rbuf  <= '0;
      r_addr  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_nxt;
      if (w_wbuf_ld) begin
        r_wbuf <= avr_din;
      end
      if (w_rbuf_ld) begin
        r_rbuf <= sram_din;
      end
      if (w_addr_ld) begin
        r_addr <= avr_addr;
      end else if (w_addr_inc) begin
        r_addr <= r_addr + c_ADDR_ONE;
      end
      if (w_err_set) begin
        r_err <= 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    w_wbuf_ld   = 1'b0;
    w_rbuf_ld   = 1'b0;
    w_addr_ld   = 1'b0;
    w_addr_inc  = 1'b0;
    w_err_set   = 1'b0;
    w_ce_n      = 1'b1;
    w_we_n      = 1'b1;
    w_oe_n      = 1'b1;
    w_sdoe      = 1'b0;
    w_adoe      = 1'b0;

    // Any strobe edge outside IDLE is a protocol violation; the access it
    // would have started is dropped.
    if ((r_state != S_IDLE) && (w_we_fall || w_oe_fall)) begin
      w_err_set = 1'b1;
    end

    case (r_state)
      S_IDLE: begin
        w_addr_ld = w_ale_rise;
        if (w_we_fall && w_oe_fall) begin
          w_err_set = 1'b1;
        end else if (w_we_fall) begin
          w_wbuf_ld   = 1'b1;
          w_state_nxt = S_WR_SETUP;
        end else if (w_oe_fall) begin
          w_state_nxt = S_RD_SETUP;
        end
      end
      S_WR_SETUP: begin
        w_ce_n      = 1'b0;
        w_sdoe      = 1'b1;
        w_wcnt_nxt  = c_WAIT;
        w_state_nxt = S_WR_PULSE;
      end
      S_WR_PULSE: begin
        w_ce_n = 1'b0;
        w_we_n = 1'b0;
        w_sdoe = 1'b1;
        if (r_wcnt == 4'd0) begin
          w_state_nxt = S_WR_HOLD;
        end else begin
          w_wcnt_nxt = r_wcnt - 4'd1;
        end
      end
      S_WR_HOLD: begin
        w_ce_n      = 1'b0;
        w_sdoe      = 1'b1;
        w_addr_inc  = w_inc_en;
        w_state_nxt = S_IDLE;
      end
      S_RD_SETUP: begin
        w_ce_n      = 1'b0;
        w_oe_n      = 1'b0;
        w_wcnt_nxt  = c_WAIT;
        w_state_nxt = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        w_ce_n = 1'b0;
        w_oe_n = 1'b0;
        if (r_wcnt == 4'd0) begin
          w_rbuf_ld   = 1'b1;
          w_state_nxt = S_RD_DRIVE;
        end else begin
          w_wcnt_nxt = r_wcnt - 4'd1;
        end
      end
      S_RD_DRIVE: begin
        // Keep driving the AVR bus until the CPU releases its read strobe.
        w_adoe = 1'b1;
        if (r_oe_sync) begin
          w_addr_inc  = w_inc_en;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Output enables decode directly from the state register, so a reset edge
  // releases every strobe and bus driver in the same cycle.
  assign sram_ce_n    = w_ce_n;
  assign sram_we_n    = w_we_n;
  assign sram_oe_n    = w_oe_n;
  assign sram_dout_oe = w_sdoe;
  assign avr_dout_oe  = w_adoe;
  assign sram_dout    = r_wbuf;
  assign avr_dout     = r_rbuf;
  assign sram_addr    = r_addr;
  assign busy         = (r_state != S_IDLE);
  assign err          = r_err;

endmodule
`default_nettype wire

// File: tb/tb_sram_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_bridge
// Purpose  : Self-checking bench for sram_bridge (DWIDTH=8, AWIDTH=17,
//            WAIT_CYCLES=2, AUTO_INC=1). Expected SRAM writes and AVR reads
//            are queued when stimulus is driven and popped by a monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_bridge;

  localparam int DW = 8;
  localparam int AW = 17;
  localparam int WC = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          avr_we_n = 1'b1;
  logic          avr_oe_n = 1'b1;
  logic          avr_ale = 1'b0;
  logic [AW-1:0] avr_addr = '0;
  logic [DW-1:0] avr_din = '0;
  logic [DW-1:0] avr_dout;
  logic          avr_dout_oe;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_din;
  logic [DW-1:0] sram_dout;
  logic          sram_dout_oe;
  logic          sram_ce_n, sram_we_n, sram_oe_n;
  logic          busy, err;

  sram_bridge #(.DWIDTH(DW), .AWIDTH(AW), .WAIT_CYCLES(WC), .AUTO_INC(1)) u_dut (
    .clk          (clk),
    .reset        (reset),
    .avr_we_n     (avr_we_n),
    .avr_oe_n     (avr_oe_n),
    .avr_ale      (avr_ale),
    .avr_addr     (avr_addr),
    .avr_din      (avr_din),
    .avr_dout     (avr_dout),
    .avr_dout_oe  (avr_dout_oe),
    .sram_addr    (sram_addr),
    .sram_din     (sram_din),
    .sram_dout    (sram_dout),
    .sram_dout_oe (sram_dout_oe),
    .sram_ce_n    (sram_ce_n),
    .sram_we_n    (sram_we_n),
    .sram_oe_n    (sram_oe_n),
    .busy         (busy),
    .err          (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Small SRAM model indexed by the low address byte.
  logic [7:0] mem [0:255];
  logic       pl_en = 1'b0;
  logic [7:0] pl_a = '0;
  logic [7:0] pl_d = '0;
  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_a] <= pl_d;
    end else if (!sram_ce_n && !sram_we_n) begin
      mem[sram_addr[7:0]] <= sram_dout;
    end
  end
  assign sram_din = mem[sram_addr[7:0]];

  // Scoreboards
  logic [AW+DW-1:0] wr_q [$];
  logic [DW-1:0]    rd_q [$];

  // Monitor state
  logic prev_we = 1'b1, prev_busy = 1'b0, prev_adoe = 1'b0;
  int   we_len = 0, busy_len = 0, last_busy = 0;
  bit   contention = 1'b0, strobe_seen = 1'b0, busy_seen = 1'b0;

  always @(posedge clk) begin
    logic [AW+DW-1:0] exp_wr;
    logic [DW-1:0]    exp_rd;
    #1;
    if (avr_dout_oe && sram_dout_oe) contention = 1'b1;
    if (!sram_ce_n || !sram_we_n || !sram_oe_n) strobe_seen = 1'b1;
    if (busy) busy_seen = 1'b1;
    if (!reset) begin
      we_len    = 0;
      busy_len  = 0;
      prev_we   = 1'b1;
      prev_busy = 1'b0;
      prev_adoe = 1'b0;
    end else begin
      if (!sram_we_n) we_len++;
      if (sram_we_n && !prev_we) begin
        // First cycle after the WE pulse: data and address must still hold.
        check("we_len", we_len, WC + 1);
        check("wr_expected", 32'(wr_q.size() != 0), 1);
        if (wr_q.size() != 0) begin
          exp_wr = wr_q.pop_front();
          check("wr_addr", sram_addr, exp_wr[AW+DW-1:DW]);
          check("wr_data", sram_dout, exp_wr[DW-1:0]);
          check("wr_hold_oe", sram_dout_oe, 1);
        end
        we_len = 0;
      end
      if (busy) begin
        busy_len++;
      end else if (prev_busy) begin
        last_busy = busy_len;
        busy_len  = 0;
      end
      if (avr_dout_oe && !prev_adoe) begin
        check("rd_expected", 32'(rd_q.size() != 0), 1);
        if (rd_q.size() != 0) begin
          exp_rd = rd_q.pop_front();
          check("rd_sb_data", avr_dout, exp_rd);
        end
      end
      prev_we   = sram_we_n;
      prev_busy = busy;
      prev_adoe = avr_dout_oe;
    end
  end

  logic [AW-1:0] exp_addr = '0;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_addr(input logic [AW-1:0] a);
    @(negedge clk);
    avr_addr = a;
    avr_ale  = 1'b1;
    tick(3);
    avr_ale  = 1'b0;
    tick(4);
    exp_addr = a;
    check("ale_addr", sram_addr, a);
  endtask

  task automatic do_write(input logic [DW-1:0] d);
    wr_q.push_back({exp_addr, d});
    @(negedge clk);
    avr_din  = d;
    avr_we_n = 1'b0;
    tick(4);
    avr_we_n = 1'b1;
    tick(8);
    exp_addr = exp_addr + 1'b1;
  endtask

  initial begin
    // ---------------- reset state ----------------
    tick(5);
    check("rst_ce_n", sram_ce_n, 1);
    check("rst_we_n", sram_we_n, 1);
    check("rst_oe_n", sram_oe_n, 1);
    check("rst_adoe", avr_dout_oe, 0);
    check("rst_sdoe", sram_dout_oe, 0);
    check("rst_adout", avr_dout, 0);
    check("rst_sdout", sram_dout, 0);
    check("rst_addr", sram_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    pl_a  = 8'h11;
    pl_d  = 8'h3C;
    pl_en = 1'b1;
    tick(1);
    pl_en = 1'b0;
    reset = 1'b1;
    tick(6);

    // ---------------- write 0xA5 at 0x00010 ----------------
    set_addr(17'h00010);
    do_write(8'hA5);
    check("wr_busy_len", last_busy, WC + 3);
    check("wr_addr_inc", sram_addr, exp_addr);
    check("wr_busy_end", busy, 0);

    // ---------------- read 0x3C at 0x00011 ----------------
    rd_q.push_back(8'h3C);
    @(negedge clk);
    avr_oe_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (i == 5) check("rd_early_oe", avr_dout_oe, 0);
      if (i == 6) begin
        check("rd_oe", avr_dout_oe, 1);
        check("rd_data", avr_dout, 8'h3C);
      end
    end
    @(negedge clk);
    avr_oe_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) check("rd_hold_oe", avr_dout_oe, 1);
      if (i == 2) begin
        check("rd_release_oe", avr_dout_oe, 0);
        check("rd_release_busy", busy, 0);
      end
    end
    exp_addr = exp_addr + 1'b1;
    tick(3);
    check("rd_addr_inc", sram_addr, exp_addr);
    check("rd_err", err, 0);

    // ---------------- auto-increment wrap ----------------
    set_addr(17'h1FFFF);
    do_write(8'h5A);
    check("wrap_addr", sram_addr, 17'h00000);

    // ---------------- busy overrun ----------------
    set_addr(17'h00040);
    wr_q.push_back({17'h00040, 8'h77});
    @(negedge clk);
    avr_din  = 8'h77;
    avr_we_n = 1'b0;
    tick(3);
    avr_we_n = 1'b1;
    tick(1);
    avr_din  = 8'h99;
    avr_we_n = 1'b0;
    tick(3);
    avr_we_n = 1'b1;
    tick(8);
    check("ovr_err", err, 1);
    check("ovr_busy_len", last_busy, WC + 3);
    check("ovr_addr", sram_addr, 17'h00041);

    // ---------------- reset mid-write ----------------
    @(negedge clk);
    avr_din  = 8'hC3;
    avr_we_n = 1'b0;
    tick(4);
    check("rmw_in_pulse", sram_we_n, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("rmw_we_n", sram_we_n, 1);
    check("rmw_ce_n", sram_ce_n, 1);
    check("rmw_sdoe", sram_dout_oe, 0);
    check("rmw_busy", busy, 0);
    @(negedge clk);
    reset     = 1'b1;
    busy_seen = 1'b0;
    tick(8);
    check("rmw_no_restart", busy_seen, 0);
    avr_we_n = 1'b1;
    tick(4);
    exp_addr = '0;
    do_write(8'hE1);
    check("rmw_new_addr", sram_addr, 17'h00001);
    check("rmw_err_clr", err, 0);

    // ---------------- simultaneous strobes ----------------
    @(negedge clk);
    strobe_seen = 1'b0;
    busy_seen   = 1'b0;
    avr_we_n    = 1'b0;
    avr_oe_n    = 1'b0;
    tick(5);
    avr_we_n = 1'b1;
    avr_oe_n = 1'b1;
    tick(5);
    check("sim_err", err, 1);
    check("sim_strobes", strobe_seen, 0);
    check("sim_busy", busy_seen, 0);
    tick(10);
    check("sim_err_sticky", err, 1);
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(4);
    check("sim_err_reset", err, 0);

    // ---------------- final ----------------
    check("wr_q_empty", wr_q.size(), 0);
    check("rd_q_empty", rd_q.size(), 0);
    check("no_contention", contention, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sram_bridge.md
# sram_bridge

Parametrised AVR-to-SRAM bus bridge, successor to the fixed 8-bit strobe-follower. It synchronises the AVR's asynchronous strobes, and latches address and write data. It sequences SRAM chip-enable, write and output-enable with a configurable wait-state count, and optionally auto-increments the address. All tri-state control is explicit (data + output-enable pairs). Pads are resolved in the CPLD top level.

## Interface
- DWIDTH, 8: data bus width.
- AWIDTH, 17: SRAM address width.
- WAIT_CYCLES, 2: extra SRAM strobe cycles; legal range 0..15.
- AUTO_INC, 1: 1 = increment the address register after every completed access.

- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-low reset.
- avr_we_n  in  1  AVR write strobe (async, active low).
- avr_oe_n  in  1  AVR read strobe (async, active low).
- avr_ale  in  1  AVR address latch enable (async, active high).
- avr_addr  in  AWIDTH  AVR address, sampled on ALE.
- avr_din  in  DWIDTH  AVR data in.
- avr_dout  out  DWIDTH  read data to AVR.
- avr_dout_oe  out  1  drive avr_dout onto the AVR pads.
- sram_addr  out  AWIDTH  SRAM address.
- sram_din  in  DWIDTH  SRAM data in.
- sram_dout  out  DWIDTH  write data to SRAM.
- sram_dout_oe  out  1  drive sram_dout onto the SRAM pads.
- sram_ce_n, sram_we_n, sram_oe_n  out  1 each  SRAM controls (active low).
- busy  out  1  high in any state other than IDLE.
- err  out  1  sticky protocol-error flag.

## Operation
- **Synchronisers.** avr_we_n, avr_oe_n and avr_ale each pass through a 2-flop synchroniser.
  - Reset value: strobes 1, ale 0.
- **Edge detection.** The block detects a falling edge on the synced we_n/oe_n and a rising edge on the synced ale.
  - An edge counts only after the synced signal has been seen inactive for at least one cycle since reset ("armed" bit).
  - A strobe held active across reset therefore triggers no access.
- **ALE.**
  - In IDLE, an ale edge loads the address register from avr_addr.
  - In any other state it is ignored (err is not set).
- **States.** IDLE, WR_SETUP, WR_PULSE, WR_HOLD, RD_SETUP, RD_WAIT, RD_DRIVE.
- **IDLE.**
  - we edge only: latch avr_din into wbuf and go to WR_SETUP.
  - oe edge only: go to RD_SETUP.
  - we and oe edges in the same cycle: no access, set err, stay in IDLE.
- **WR_SETUP** (1 cycle): sram_ce_n=0, sram_dout=wbuf, sram_dout_oe=1. Next state WR_PULSE.
- **WR_PULSE** (WAIT_CYCLES+1 cycles, wait counter): sram_we_n=0, sram_ce_n=0, data still driven. Next state WR_HOLD.
- **WR_HOLD** (1 cycle): sram_we_n=1, ce_n=0, data still driven.
  - On exit: if AUTO_INC, the address is incremented modulo 2^AWIDTH. Next state IDLE.
- **RD_SETUP** (1 cycle): sram_ce_n=0, sram_oe_n=0. Next state RD_WAIT.
- **RD_WAIT** (WAIT_CYCLES+1 cycles): ce_n=0, oe_n=0.
  - On the final cycle's edge, sram_din is captured into rbuf. Next state RD_DRIVE.
- **RD_DRIVE.** sram_ce_n=1, sram_oe_n=1, avr_dout=rbuf, avr_dout_oe=1.
  - Held until the synced oe_n is seen high.
  - Then avr_dout_oe=0, the address increments if AUTO_INC, and the FSM returns to IDLE.
- **Strobe edge while busy.** The edge is ignored and err is set.
- **Contention rule.** avr_dout_oe and sram_dout_oe are never high in the same cycle. sram_dout_oe=1 only in WR_*; avr_dout_oe=1 only in RD_DRIVE.
- **err.** Cleared only by reset.

## Timing
- **Reset values.**
  - sram_ce_n=1, sram_we_n=1, sram_oe_n=1.
  - avr_dout_oe=0, sram_dout_oe=0, avr_dout=0, sram_dout=0.
  - sram_addr=0, wbuf=0, rbuf=0.
  - busy=0, err=0, state IDLE, wait counter 0.
- **Reset mid-access.** At the reset edge all SRAM strobes and output enables go inactive; there is no completion cycle.
- **Detection latency.** A strobe pin first sampled low at edge k is detected in the cycle after edge k+1. The FSM leaves IDLE at edge k+2, and avr_din is latched at that same edge.
- **AVR hold requirement.** The AVR must hold address and data stable for at least 3 clk after strobe assertion.
- **Write length.** WAIT_CYCLES+3 cycles with busy=1; sram_we_n is low for exactly WAIT_CYCLES+1 cycles.
- **Write data window.** Data is valid on sram_dout one cycle before sram_we_n falls and one cycle after it rises.
- **Read length.** Read data is on avr_dout WAIT_CYCLES+2 cycles after leaving IDLE, i.e. 4+WAIT_CYCLES clk after the pin falls.
  - The AVR oe_n low time must therefore be at least (WAIT_CYCLES+5) clk.
- **Read release.** The release latency from the oe_n pin rising is 3 clk, then busy drops.
- **Wait counter.** 4 bits; it loads WAIT_CYCLES on state entry and exits at 0.

## Test plan
- **Write, WAIT_CYCLES=2, AUTO_INC=1.**
  - Stimulus: ALE with addr 0x00010, then we_n low with din 0xA5.
  - Required: sram_we_n low for exactly 3 cycles at addr 0x00010 with sram_dout=0xA5; busy high for 5 cycles; sram_addr is then 0x00011.
- **Read.**
  - Stimulus: SRAM model returns 0x3C at 0x00011; pulse oe_n low for 10 clk.
  - Required: avr_dout=0xA5 is not seen; avr_dout=0x3C with avr_dout_oe=1 from clk 6 after the pin falls; avr_dout_oe=0 three clk after the pin rises.
- **Auto-increment wrap.**
  - Stimulus: address 0x1FFFF, one write.
  - Required: the write lands at 0x1FFFF, then sram_addr=0x00000.
- **Simultaneous strobes.**
  - Stimulus: we_n and oe_n fall on the same clk.
  - Required: no SRAM strobe toggles, err=1, busy stays 0; err stays 1 until reset.
- **Reset mid-write.**
  - Stimulus: reset=0 during WR_PULSE while we_n is held low.
  - Required: next edge sram_we_n=1, sram_ce_n=1, sram_dout_oe=0, busy=0; no new write until we_n has been seen high and then falls again.
- **Busy overrun.**
  - Stimulus: a second we_n fall during a write.
  - Required: the second access is ignored, err=1, and the first write completes with its original data.
